byte_deser: RTL and testbench
=============================

# byte_deser

Receive-side counterpart of `byte_ser`. Collects bytes from the UART receiver (`rx_d` / `rx_rdy`, produced in the `clk_uart` domain) into a 256-bit frame in the `clk` domain. Reports completion with a one-cycle `dout_valid` pulse, so command handlers see whole multi-byte operands instead of single bytes.

## Interface

Parameters:
- `WIDTH_BYTES`, 32: frame capacity in bytes; `dout` is `8*WIDTH_BYTES` bits.
- `CNT_W`, 6: width of length/count fields; must hold `WIDTH_BYTES`.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `din`  in  8  received byte (`rx_d`); stable while `din_valid` is high.
- `din_valid`  in  1  `rx_rdy`; asynchronous level, synchronized internally.
- `start`  in  1  one-cycle pulse that arms a new frame.
- `frame_len`  in  CNT_W  bytes expected; sampled only when `start` is high.
- `dout`  out  8*WIDTH_BYTES  assembled frame.
- `dout_valid`  out  1  one-cycle pulse when the frame is complete.
- `busy`  out  1  high in COLLECT.
- `count`  out  CNT_W  bytes captured so far in the current frame.
- `drop`  out  1  one-cycle pulse when a byte arrives outside COLLECT.

## Operation

- Input path: 2-flop synchronizer on `din_valid`, then a rising-edge detector. `byte_evt` is a single `clk` cycle per `din_valid` rising edge. `din` is sampled in the `byte_evt` cycle.
- States:
  - IDLE to COLLECT on `start`.
  - COLLECT to DONE when the captured byte makes `count == len`.
  - DONE to IDLE unconditionally after one cycle.
- On `start`, in any state:
  - `len` is set to `frame_len`. A value of 0 means `WIDTH_BYTES`; values above `WIDTH_BYTES` clamp to `WIDTH_BYTES`.
  - `count` and `dout` clear to 0; state becomes COLLECT.
- On `byte_evt` in COLLECT: byte `count` is written to `dout[8*count +: 8]`, and `count` increments. The first byte received lands in `dout[7:0]`.
- On `byte_evt` in IDLE or DONE: the byte is discarded, `drop` pulses, and `dout` and `count` are unchanged.
- `start` and `byte_evt` in the same cycle: `start` applies, and the byte is captured as byte 0 of the new frame (`count` becomes 1). If `len` is 1, go directly to DONE.
- `start` during COLLECT aborts the partial frame without a `dout_valid`.
- `dout` holds the last frame, including unused zero bytes, until the next `start`.
- `count` never exceeds `len`, so there is no wrap-around.

## Timing

- Reset values:
  - `dout`, `count`, `len`, and the sync/edge flops all 0.
  - `dout_valid`, `busy`, `drop` all 0.
  - State IDLE.
- Reset may assert mid-frame; the frame is lost and no pulse is emitted.
- Latency from `din_valid` rising to capture: the `dout`/`count` update is visible at the 3rd `clk` rising edge after the rise is seen by the first sync flop.
- `din` must be stable for at least 3 `clk` cycles after `din_valid` rises. The UART provides about 542 cycles.
- `dout_valid` is registered: it is high in the cycle after the final capture (the DONE state), and `dout` is complete in that same cycle.
- `busy` is 1 only in COLLECT.
- `drop` is registered and has the same timing as a capture would.
- A `start` issued in the DONE cycle is honoured; `dout_valid` is still emitted for the finished frame.
- `din_valid` held high produces exactly one byte. It must go low for at least 2 `clk` cycles before the next byte is recognised.

## Structure

- Shared package (with `byte_ser`) holds:
  - `WIDTH_BYTES` = 32.
  - `CNT_W` = 6.
  - State encoding IDLE/COLLECT/DONE.
- One sub-module, `pulse_sync`: 2-flop synchronizer plus rising-edge detector, with async active-high `reset`. It is reusable for other `clk_uart` to `clk` strobes.
- Top-level instantiation:
  - `din` = `rx_d`, `din_valid` = `rx_rdy`.
  - `start` comes from the command decoder.

## Test plan

- Reset, then `start` with `frame_len`=4, then bytes 0x11,0x22,0x33,0x44 → `dout[31:0]`=0x44332211, upper bits 0, one `dout_valid` pulse, `busy` falls in the same cycle as the pulse.
- `frame_len`=0, then 32 bytes 0x00..0x1F → `dout[255:248]`=0x1F, `dout[7:0]`=0x00, `count`=32, exactly one `dout_valid`.
- Byte 0xA5 with no `start` → `drop` pulses once, `dout` stays 0. A 33rd byte after a 32-byte frame → `drop`.
- `start` (`frame_len`=3), 2 bytes, then `start` (`frame_len`=2) coincident with byte 0x77 → first frame aborted with no pulse. Next byte 0x88 → `dout[15:0]`=0x8877, one pulse.
- `din_valid` held high for 1000 cycles with `din`=0x5A, `frame_len`=2 → `count`=1 only, no `dout_valid`.
- Reset asserted after 2 of 4 bytes → all outputs 0 immediately, no `dout_valid`. After release, a fresh frame works normally.

Source files
------------

// File: rtl/byte_deser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : byte_deser_pkg
// Brief    : Shared constants and state encoding for byte_ser / byte_deser.
// Revision : 1.0
// ============================================================================
package byte_deser_pkg;

    localparam int WIDTH_BYTES = 32;
    localparam int CNT_W       = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/byte_deser_pulse_sync.sv
`default_nettype none
// ============================================================================
// Module   : pulse_sync
// Brief    : 2-flop synchronizer plus rising-edge detector for a foreign-domain
//            level; emits one clk-cycle pulse per rising edge.
// Revision : 1.0
// ============================================================================
module pulse_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_level,
    output logic o_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_level;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_pulse = r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/byte_deser.sv
`default_nettype none
// ============================================================================
// Module   : byte_deser
// Brief    : Assembles UART bytes into a WIDTH_BYTES frame in the clk domain.
// Revision : 1.0
// ============================================================================
module byte_deser #(
    parameter int WIDTH_BYTES = byte_deser_pkg::WIDTH_BYTES,
    parameter int CNT_W       = byte_deser_pkg::CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               din,
    input  logic                     din_valid,
    input  logic                     start,
    input  logic [CNT_W-1:0]         frame_len,
    output logic [8*WIDTH_BYTES-1:0] dout,
    output logic                     dout_valid,
    output logic                     busy,
    output logic [CNT_W-1:0]         count,
    output logic                     drop
);

    import byte_deser_pkg::*;

    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(WIDTH_BYTES);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    state_t                   r_state;
    state_t                   w_state_n;
    logic [CNT_W-1:0]         r_count;
    logic [CNT_W-1:0]         w_count_n;
    logic [CNT_W-1:0]         r_len;
    logic [CNT_W-1:0]         w_len_n;
    logic [8*WIDTH_BYTES-1:0] r_dout;
    logic [8*WIDTH_BYTES-1:0] w_dout_n;
    logic                     r_drop;
    logic                     w_drop_n;
    logic                     w_byte_evt;
    logic [CNT_W-1:0]         w_start_len;

    pulse_sync u_pulse_sync (
        .clk     (clk),
        .reset   (reset),
        .i_level (din_valid),
        .o_pulse (w_byte_evt)
    );

    // A zero length means a full frame; oversize requests saturate.
    assign w_start_len = ((frame_len == '0) || (frame_len > C_FULL)) ? C_FULL : frame_len;

    always_comb begin
        w_state_n = r_state;
        w_count_n = r_count;
        w_len_n   = r_len;
        w_dout_n  = r_dout;
        w_drop_n  = 1'b0;

        if (start) begin
            w_len_n   = w_start_len;
            w_count_n = '0;
            w_dout_n  = '0;
            w_state_n = COLLECT;
            if (w_byte_evt) begin
                w_dout_n[7:0] = din;
                w_count_n     = C_ONE;
                if (w_start_len == C_ONE) begin
                    w_state_n = DONE;
                end
            end
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_byte_evt) begin
                        for (int i = 0; i < WIDTH_BYTES; i++) begin
                            if (r_count == CNT_W'(i)) begin
                                w_dout_n[8*i +: 8] = din;
                            end
                        end
                        w_count_n = r_count + C_ONE;
                        if ((r_count + C_ONE) == r_len) begin
                            w_state_n = DONE;
                        end
                    end
                end
                DONE: begin
                    w_state_n = IDLE;
                    w_drop_n  = w_byte_evt;
                end
                default: begin
                    w_state_n = IDLE;
                    w_drop_n  = w_byte_evt;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_len   <= '0;
            r_dout  <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_count <= w_count_n;
            r_len   <= w_len_n;
            r_dout  <= w_dout_n;
            r_drop  <= w_drop_n;
        end
    end

    assign dout       = r_dout;
    assign count      = r_count;
    assign drop       = r_drop;
    assign busy       = (r_state == COLLECT);
    assign dout_valid = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_byte_deser.sv
`default_nettype none
// ============================================================================
// Module   : tb_byte_deser
// Brief    : Self-checking bench for byte_deser with a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_byte_deser;

    localparam int WB = 32;
    localparam int CW = 6;

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      din;
    logic            din_valid;
    logic            start;
    logic [CW-1:0]   frame_len;
    logic [8*WB-1:0] dout;
    logic            dout_valid;
    logic            busy;
    logic [CW-1:0]   count;
    logic            drop;

    int total = 0;
    int bad   = 0;
    int n_valid   = 0;
    int n_drop    = 0;
    int n_overlap = 0;
    int v0;
    int d0;
    int fl;
    int len;
    logic [7:0]   q[$];
    logic [255:0] snap;

    byte_deser dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .start      (start),
        .frame_len  (frame_len),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .count      (count),
        .drop       (drop)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dout_valid) n_valid++;
        if (drop) n_drop++;
        if (dout_valid && busy) n_overlap++;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input int f);
        frame_len = f[CW-1:0];
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        din       = b;
        din_valid = 1'b1;
        cyc(4);
        din_valid = 1'b0;
        cyc(3);
    endtask

    // Frame image: received bytes in arrival order from the LSB, zero above.
    function automatic logic [255:0] model_frame();
        logic [255:0] r;
        r = '0;
        foreach (q[i]) r[8*i +: 8] = q[i];
        return r;
    endfunction

    function automatic int eff_len(input int f);
        return ((f == 0) || (f > WB)) ? WB : f;
    endfunction

    initial begin
        reset = 1'b1; din = '0; din_valid = 1'b0; start = 1'b0; frame_len = '0;
        cyc(3);
        check("rst_dout", dout, '0);
        check("rst_count", count, '0);
        check("rst_valid", dout_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop, 0);
        reset = 1'b0;
        cyc(2);

        // Stray byte with no frame armed
        d0 = n_drop;
        send_byte(8'hA5);
        check("stray_drop", n_drop - d0, 1);
        check("stray_dout", dout, '0);
        check("stray_count", count, '0);

        // Four-byte frame
        v0 = n_valid;
        q = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_start(4);
        check("f4_busy", busy, 1);
        foreach (q[i]) send_byte(q[i]);
        check("f4_dout", dout, model_frame());
        check("f4_low32", dout[31:0], 32'h44332211);
        check("f4_valid", n_valid - v0, 1);
        check("f4_overlap", n_overlap, 0);
        check("f4_count", count, 4);
        check("f4_busy_end", busy, 0);

        // Full 32-byte frame via frame_len=0, then an extra byte
        v0 = n_valid;
        q.delete();
        for (int i = 0; i < WB; i++) q.push_back(8'(i));
        do_start(0);
        foreach (q[i]) send_byte(q[i]);
        check("f32_dout", dout, model_frame());
        check("f32_top", dout[255:248], 8'h1F);
        check("f32_count", count, 32);
        check("f32_valid", n_valid - v0, 1);
        d0 = n_drop;
        snap = dout;
        send_byte(8'hEE);
        check("f33_drop", n_drop - d0, 1);
        check("f33_dout", dout, snap);

        // Abort by a start coincident with a byte event
        v0 = n_valid;
        do_start(3);
        send_byte(8'h01);
        send_byte(8'h02);
        check("ab_count2", count, 2);
        din = 8'h77;
        din_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        frame_len = CW'(2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc(2);
        din_valid = 1'b0;
        cyc(3);
        check("ab_count1", count, 1);
        check("ab_busy", busy, 1);
        check("ab_novalid", n_valid - v0, 0);
        send_byte(8'h88);
        check("ab_dout", dout, {240'b0, 16'h8877});
        check("ab_valid", n_valid - v0, 1);

        // din_valid held high yields a single byte
        v0 = n_valid;
        do_start(2);
        din = 8'h5A;
        din_valid = 1'b1;
        cyc(1000);
        check("hold_count", count, 1);
        check("hold_novalid", n_valid - v0, 0);
        check("hold_dout", dout, {248'b0, 8'h5A});
        din_valid = 1'b0;
        cyc(3);

        // Reset in the middle of a frame
        v0 = n_valid;
        do_start(4);
        send_byte(8'hC1);
        send_byte(8'hC2);
        reset = 1'b1;
        #1;
        check("mr_dout", dout, '0);
        check("mr_count", count, '0);
        check("mr_busy", busy, 0);
        check("mr_valid", dout_valid, 0);
        cyc(2);
        reset = 1'b0;
        cyc(2);
        check("mr_novalid", n_valid - v0, 0);

        // Random frames against the frame model
        for (int k = 0; k < 5; k++) begin
            v0 = n_valid;
            fl = int'($urandom_range(0, 63));
            len = eff_len(fl);
            q.delete();
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            do_start(fl);
            foreach (q[i]) send_byte(q[i]);
            check("rnd_dout", dout, model_frame());
            check("rnd_count", count, len);
            check("rnd_valid", n_valid - v0, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
